// File: rtl/register_file.sv
// Purpose: 32-entry integer register file for the single-cycle RISC-V core.
//          Two combinational read ports feed the ALU operands, and one write
//          port captures the writeback value on the rising clock edge.
//          Register x0 has no storage and always reads as zero.
// Ports:
//   clk        - clock, registers update on the rising edge
//   rst_n      - asynchronous active-low reset, clears every register
//   readReg1   - read port 1 index (rs1)
//   readReg2   - read port 2 index (rs2)
//   writeReg   - write port index (rd)
//   writeData  - value written to writeReg
//   regWrite   - write enable, sampled on the rising edge
//   readData1  - contents of register readReg1 (combinational)
//   readData2  - contents of register readReg2 (combinational)
module register_file #(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AddrWidth-1:0] readReg1,
    input  logic [AddrWidth-1:0] readReg2,
    input  logic [AddrWidth-1:0] writeReg,
    input  logic [Width-1:0]     writeData,
    input  logic                 regWrite,
    output logic [Width-1:0]     readData1,
    output logic [Width-1:0]     readData2
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    // Storage exists only for x1..x(Depth-1); x0 is synthesized as constant zero.
    logic [Width-1:0] regs_q [1:Depth-1];
    logic [Width-1:0] regs_d [1:Depth-1];
    logic             wr_en_c;

    // A write to x0 is dropped here so it never reaches any storage.
    assign wr_en_c = regWrite && (writeReg != '0);

    // Next-state: at most one entry takes writeData.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_c) begin
            for (int unsigned i = 1; i < Depth; i++) begin
                if (writeReg == AddrWidth'(i)) begin
                    regs_d[i] = writeData;
                end
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes come straight from the flops: no write-to-read bypass, since
    // a bypass would close a loop through the ALU back onto writeData.
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        for (int unsigned i = 1; i < Depth; i++) begin
            if (readReg1 == AddrWidth'(i)) begin
                readData1 = regs_q[i];
            end
            if (readReg2 == AddrWidth'(i)) begin
                readData2 = regs_q[i];
            end
        end
    end

endmodule
